// File: rtl/deserializer.sv
// DDR line deserializer: hunts an idle run, frames sync + 4 data pairs, delivers one byte per 5-cycle frame.
// Byte and data_valid register on the edge sampling the 4th data pair; no backpressure, every frame is delivered.
module deserializer #(
  parameter int unsigned IDLE_MIN    = 16,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] rx_pair,
  input  logic       err_clr,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       locked,
  output logic       frame_err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {HUNT, ARMED, DATA, SYNC} state_t;

  localparam logic [1:0] PAIR_IDLE = 2'b00;
  localparam logic [1:0] PAIR_SYNC = 2'b10;
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_MIN - 1);
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_FRAMES - 1);

  state_t     state, state_nxt;
  logic [7:0] idle_cnt, idle_cnt_nxt;
  logic [1:0] slot, slot_nxt;
  logic [7:0] good_cnt, good_cnt_nxt;
  logic [5:0] shift, shift_nxt;
  logic [7:0] data_out_nxt;
  logic       data_valid_nxt;
  logic       locked_nxt;
  logic       frame_err_nxt;
  logic [7:0] err_count_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HUNT;
      idle_cnt   <= 8'd0;
      slot       <= 2'd0;
      good_cnt   <= 8'd0;
      shift      <= 6'd0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      locked     <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      state      <= state_nxt;
      idle_cnt   <= idle_cnt_nxt;
      slot       <= slot_nxt;
      good_cnt   <= good_cnt_nxt;
      shift      <= shift_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
      locked     <= locked_nxt;
      frame_err  <= frame_err_nxt;
      err_count  <= err_count_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    idle_cnt_nxt   = idle_cnt;
    slot_nxt       = slot;
    good_cnt_nxt   = good_cnt;
    shift_nxt      = shift;
    data_out_nxt   = data_out;
    data_valid_nxt = 1'b0;
    locked_nxt     = locked;
    frame_err_nxt  = 1'b0;
    err_count_nxt  = err_count;

    case (state)
      HUNT: begin
        if (rx_pair == PAIR_IDLE) begin
          if (idle_cnt != 8'hFF) idle_cnt_nxt = idle_cnt + 8'd1;
          // arm on the edge that samples the IDLE_MIN-th idle
          if (idle_cnt >= IDLE_LAST) state_nxt = ARMED;
        end else begin
          idle_cnt_nxt = 8'd0;
        end
      end

      ARMED: begin
        if (rx_pair == PAIR_SYNC) begin
          state_nxt = DATA;
          slot_nxt  = 2'd0;
        end else if (rx_pair != PAIR_IDLE) begin
          state_nxt    = HUNT;
          idle_cnt_nxt = 8'd0;
        end
      end

      DATA: begin
        shift_nxt = {shift[3:0], rx_pair};
        slot_nxt  = slot + 2'd1;
        if (slot == 2'd3) begin
          data_out_nxt   = {shift, rx_pair};
          data_valid_nxt = 1'b1;
          if (good_cnt != 8'hFF) good_cnt_nxt = good_cnt + 8'd1;
          if (good_cnt >= LOCK_LAST) locked_nxt = 1'b1;
          state_nxt = SYNC;
        end
      end

      SYNC: begin
        if (rx_pair == PAIR_SYNC) begin
          state_nxt = DATA;
          slot_nxt  = 2'd0;
        end else if (rx_pair == PAIR_IDLE) begin
          // orderly stop: this idle already counts toward the next hunt
          state_nxt    = HUNT;
          idle_cnt_nxt = 8'd1;
          good_cnt_nxt = 8'd0;
          locked_nxt   = 1'b0;
        end else begin
          state_nxt     = HUNT;
          idle_cnt_nxt  = 8'd0;
          good_cnt_nxt  = 8'd0;
          locked_nxt    = 1'b0;
          frame_err_nxt = 1'b1;
          if (err_count != 8'hFF) err_count_nxt = err_count + 8'd1;
        end
      end

      default: begin
        state_nxt    = HUNT;
        idle_cnt_nxt = 8'd0;
      end
    endcase

    if (err_clr) err_count_nxt = 8'd0;
  end

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: directed scenarios plus random line traffic against a stream-level model.
module tb_deserializer;
  localparam int IDLE_MIN    = 16;
  localparam int LOCK_FRAMES = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] rx_pair = 2'b00;
  logic       err_clr = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       locked;
  logic       frame_err;
  logic [7:0] err_count;

  deserializer #(.IDLE_MIN(IDLE_MIN), .LOCK_FRAMES(LOCK_FRAMES)) dut (
    .clk(clk), .reset_n(reset_n), .rx_pair(rx_pair), .err_clr(err_clr),
    .data_out(data_out), .data_valid(data_valid), .locked(locked),
    .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // stream-level model: framed flag, position in frame, byte accumulated arithmetically
  bit         m_in_frame, m_armed, m_locked, m_dv, m_ferr;
  int         m_idle_run, m_phase, m_acc, m_good, m_err;
  logic [7:0] m_dout;
  int         dv_seen, ferr_seen;

  task automatic model_reset();
    m_in_frame = 0; m_armed = 0; m_locked = 0; m_dv = 0; m_ferr = 0;
    m_idle_run = 0; m_phase = 0; m_acc = 0; m_good = 0; m_err = 0; m_dout = 8'h00;
  endtask

  task automatic model_step(input logic [1:0] p, input logic clr);
    m_dv = 0;
    m_ferr = 0;
    if (!m_in_frame) begin
      if (m_armed) begin
        if (p == 2'b10) begin
          m_in_frame = 1; m_phase = 1; m_acc = 0; m_armed = 0;
        end else if (p != 2'b00) begin
          m_armed = 0; m_idle_run = 0;
        end
      end else if (p == 2'b00) begin
        m_idle_run++;
        if (m_idle_run >= IDLE_MIN) m_armed = 1;
      end else begin
        m_idle_run = 0;
      end
    end else if (m_phase == 0) begin
      if (p == 2'b10) begin
        m_phase = 1; m_acc = 0;
      end else if (p == 2'b00) begin
        m_in_frame = 0; m_idle_run = 1; m_good = 0; m_locked = 0;
      end else begin
        m_ferr = 1;
        if (m_err < 255) m_err++;
        m_good = 0; m_locked = 0; m_in_frame = 0; m_idle_run = 0;
      end
    end else begin
      m_acc = m_acc * 4 + int'(p);
      if (m_phase == 4) begin
        m_dout = 8'(m_acc);
        m_dv = 1;
        m_good++;
        if (m_good >= LOCK_FRAMES) m_locked = 1;
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
    if (clr) m_err = 0;
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic step_cycle(input logic [1:0] p, input logic clr);
    rx_pair = p;
    err_clr = clr;
    @(posedge clk);
    model_step(p, clr);
    #1;
    if (data_valid === 1'b1) dv_seen++;
    if (frame_err === 1'b1) ferr_seen++;
    @(negedge clk);
  endtask

  task automatic send_idles(input int n);
    repeat (n) step_cycle(2'b00, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] b);
    step_cycle(2'b10, 1'b0);
    for (int k = 3; k >= 0; k--) step_cycle(2'(b >> (2 * k)), 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rx_pair = 2'b00;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    dv_seen = 0;
    ferr_seen = 0;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    n_cmp++;
    if ({data_out, data_valid, locked, frame_err, err_count} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got dout=%h dv=%b lock=%b ferr=%b errc=%0d want all zero",
               data_out, data_valid, locked, frame_err, err_count);
    end
    do_reset();
    n_cmp++;
    if ({data_out, data_valid, locked, frame_err, err_count} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_release: got dout=%h dv=%b lock=%b ferr=%b errc=%0d want all zero",
               data_out, data_valid, locked, frame_err, err_count);
    end
  endtask

  task automatic test_startup();
    do_reset();
    send_idles(16);
    step_cycle(2'b10, 1'b0);
    step_cycle(2'b11, 1'b0);
    step_cycle(2'b00, 1'b0);
    step_cycle(2'b10, 1'b0);
    n_cmp++;
    if (dv_seen !== 0) begin
      n_bad++; $display("FAIL startup_early_dv: got %0d pulses want 0", dv_seen);
    end
    step_cycle(2'b01, 1'b0);
    n_cmp++;
    if (data_valid !== 1'b1 || data_out !== 8'hC9 || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL startup_byte: got dv=%b dout=%h ferr=%b want dv=1 dout=c9 ferr=0",
               data_valid, data_out, frame_err);
    end
    step_cycle(2'b00, 1'b0);
    n_cmp++;
    if (data_valid !== 1'b0 || data_out !== 8'hC9 || locked !== 1'b0 || ferr_seen !== 0) begin
      n_bad++;
      $display("FAIL startup_hold: got dv=%b dout=%h lock=%b ferrs=%0d want dv=0 dout=c9 lock=0 ferrs=0",
               data_valid, data_out, locked, ferr_seen);
    end
  endtask

  task automatic test_lock();
    do_reset();
    send_idles(16);
    send_frame(8'hA5);
    n_cmp++;
    if (data_valid !== 1'b1 || data_out !== 8'hA5 || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_frame1: got dv=%b dout=%h lock=%b want dv=1 dout=a5 lock=0", data_valid, data_out, locked);
    end
    send_frame(8'h3C);
    n_cmp++;
    if (data_valid !== 1'b1 || data_out !== 8'h3C || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL lock_frame2: got dv=%b dout=%h lock=%b want dv=1 dout=3c lock=1", data_valid, data_out, locked);
    end
    send_frame(8'hFF);
    n_cmp++;
    if (data_out !== 8'hFF || locked !== 1'b1 || dv_seen !== 3) begin
      n_bad++;
      $display("FAIL lock_frame3: got dout=%h lock=%b dvs=%0d want dout=ff lock=1 dvs=3", data_out, locked, dv_seen);
    end
  endtask

  task automatic test_short_idle();
    do_reset();
    send_idles(15);
    send_frame(8'h5A);
    n_cmp++;
    if (dv_seen !== 0) begin
      n_bad++; $display("FAIL short_idle_reject: got %0d pulses want 0", dv_seen);
    end
    do_reset();
    send_idles(15);
    send_idles(1);
    send_frame(8'h5A);
    n_cmp++;
    if (dv_seen !== 1 || data_out !== 8'h5A) begin
      n_bad++; $display("FAIL short_idle_accept: got dvs=%0d dout=%h want dvs=1 dout=5a", dv_seen, data_out);
    end
  endtask

  task automatic test_bad_sync();
    do_reset();
    send_idles(16);
    send_frame(8'hA5);
    send_frame(8'h3C);
    step_cycle(2'b11, 1'b0);
    n_cmp++;
    if (frame_err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || data_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_sync_pulse: got ferr=%b errc=%0d lock=%b dv=%b want ferr=1 errc=1 lock=0 dv=0",
               frame_err, err_count, locked, data_valid);
    end
    step_cycle(2'b00, 1'b0);
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_bad++; $display("FAIL bad_sync_one_cycle: got ferr=%b want 0", frame_err);
    end
    dv_seen = 0;
    send_frame(8'h12);
    send_idles(5);
    send_frame(8'h34);
    n_cmp++;
    if (dv_seen !== 0) begin
      n_bad++; $display("FAIL bad_sync_no_resync: got %0d pulses want 0", dv_seen);
    end
    send_idles(16);
    send_frame(8'h77);
    n_cmp++;
    if (dv_seen !== 1 || data_out !== 8'h77 || ferr_seen !== 1) begin
      n_bad++;
      $display("FAIL bad_sync_recover: got dvs=%0d dout=%h ferrs=%0d want dvs=1 dout=77 ferrs=1",
               dv_seen, data_out, ferr_seen);
    end
  endtask

  task automatic test_stop_mimic();
    do_reset();
    send_idles(16);
    send_frame(8'hA5);
    send_frame(8'h3C);
    step_cycle(2'b00, 1'b0);
    n_cmp++;
    if (locked !== 1'b0 || frame_err !== 1'b0 || err_count !== 8'd0 || data_out !== 8'h3C) begin
      n_bad++;
      $display("FAIL stop_unlock: got lock=%b ferr=%b errc=%0d dout=%h want lock=0 ferr=0 errc=0 dout=3c",
               locked, frame_err, err_count, data_out);
    end
    send_frame(8'h5A);
    n_cmp++;
    if (dv_seen !== 2 || ferr_seen !== 0) begin
      n_bad++; $display("FAIL stop_no_frame: got dvs=%0d ferrs=%0d want dvs=2 ferrs=0", dv_seen, ferr_seen);
    end
    do_reset();
    send_idles(16);
    send_frame(8'h88);
    n_cmp++;
    if (data_valid !== 1'b1 || data_out !== 8'h88) begin
      n_bad++; $display("FAIL mimic_byte: got dv=%b dout=%h want dv=1 dout=88", data_valid, data_out);
    end
    send_frame(8'h12);
    n_cmp++;
    if (dv_seen !== 2 || data_out !== 8'h12 || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL mimic_next: got dvs=%0d dout=%h lock=%b want dvs=2 dout=12 lock=1", dv_seen, data_out, locked);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_idles(16);
    send_frame(8'hA5);
    step_cycle(2'b11, 1'b0);
    send_idles(16);
    send_frame(8'hA5);
    send_frame(8'h3C);
    step_cycle(2'b10, 1'b0);
    step_cycle(2'b01, 1'b0);
    step_cycle(2'b10, 1'b0);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({data_out, data_valid, locked, frame_err, err_count} !== 19'd0) begin
      n_bad++;
      $display("FAIL midframe_async: got dout=%h dv=%b lock=%b ferr=%b errc=%0d want all zero",
               data_out, data_valid, locked, frame_err, err_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    dv_seen = 0;
    ferr_seen = 0;
    reset_n = 1'b1;
    step_cycle(2'b11, 1'b0);
    step_cycle(2'b01, 1'b0);
    send_idles(5);
    send_frame(8'hAB);
    n_cmp++;
    if (dv_seen !== 0 || ferr_seen !== 0) begin
      n_bad++; $display("FAIL midframe_no_pulse: got dvs=%0d ferrs=%0d want 0 0", dv_seen, ferr_seen);
    end
    send_idles(16);
    send_frame(8'hCD);
    n_cmp++;
    if (dv_seen !== 1 || data_out !== 8'hCD) begin
      n_bad++; $display("FAIL midframe_recover: got dvs=%0d dout=%h want dvs=1 dout=cd", dv_seen, data_out);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send_idles(16);
      send_frame(8'($urandom));
      step_cycle((i % 2 == 0) ? 2'b11 : 2'b01, 1'b0);
    end
    n_cmp++;
    if (err_count !== 8'd255 || ferr_seen !== 300) begin
      n_bad++; $display("FAIL sat_count: got errc=%0d ferrs=%0d want errc=255 ferrs=300", err_count, ferr_seen);
    end
    step_cycle(2'b00, 1'b1);
    n_cmp++;
    if (err_count !== 8'd0) begin
      n_bad++; $display("FAIL sat_clear: got errc=%0d want 0", err_count);
    end
    send_idles(16);
    send_frame(8'h42);
    step_cycle(2'b11, 1'b1);
    n_cmp++;
    if (frame_err !== 1'b1 || err_count !== 8'd0) begin
      n_bad++; $display("FAIL clr_vs_err: got ferr=%b errc=%0d want ferr=1 errc=0", frame_err, err_count);
    end
  endtask

  task automatic test_random();
    logic [2:0] q[$];
    logic [7:0] b;
    int         n;
    do_reset();
    for (int s = 0; s < 60; s++) begin
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(6, 15) : $urandom_range(16, 22);
      repeat (n) q.push_back(3'b000);
      if ($urandom_range(0, 5) == 0) q.push_back({1'b0, 2'($urandom_range(1, 3))});
      n = $urandom_range(1, 4);
      for (int f = 0; f < n; f++) begin
        b = 8'($urandom);
        q.push_back(3'b010);
        for (int k = 3; k >= 0; k--) q.push_back({1'b0, 2'(b >> (2 * k))});
      end
      if ($urandom_range(0, 2) == 0) q.push_back({1'b0, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01});
    end
    foreach (q[i]) begin
      step_cycle(q[i][1:0], ($urandom_range(0, 19) == 0));
      n_cmp++;
      if ({data_valid, data_out, frame_err, locked, err_count} !== {m_dv, m_dout, m_ferr, m_locked, 8'(m_err)}) begin
        n_bad++;
        $display("FAIL random_cycle%0d: got dv=%b dout=%h ferr=%b lock=%b errc=%0d want dv=%b dout=%h ferr=%b lock=%b errc=%0d",
                 i, data_valid, data_out, frame_err, locked, err_count, m_dv, m_dout, m_ferr, m_locked, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_lock();
    test_short_idle();
    test_bad_sync();
    test_stop_mimic();
    test_reset_mid_frame();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 The block SHALL have parameter IDLE_MIN, default 16, giving the consecutive idle pairs required before a sync is accepted (range 1..255).
REQ-002 The block SHALL have parameter LOCK_FRAMES, default 2, giving the consecutive good frames required to assert locked (range 1..255).
REQ-003 clk  input  1  forwarded link clock (the transmitter's txclk); all logic on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 rx_pair  input  2  DDR line bits from the external input register, valid at each rising clk; [1] = bit sent in clk-high phase, [0] = bit sent in clk-low phase.
REQ-006 err_clr  input  1  synchronous clear of err_count.
REQ-007 data_out  output  8  last received byte, registered.
REQ-008 data_valid  output  1  one-cycle pulse, data_out updated.
REQ-009 locked  output  1  link framed and stable.
REQ-010 frame_err  output  1  one-cycle pulse on bad sync slot.
REQ-011 err_count  output  8  saturating count of frame_err pulses.

Function
REQ-012 Line format SHALL be: idle pair 2'b00; sync pair 2'b10; frame = one sync pair, then 4 data pairs carrying bits {7,6},{5,4},{3,2},{1,0} in that order, [1] = higher bit; the next frame's sync immediately follows the 4th data pair (5-cycle frame period).
REQ-013 The FSM SHALL have states HUNT, ARMED, DATA, SYNC, plus an 8-bit saturating idle_cnt, a 2-bit slot counter, an 8-bit saturating good_cnt, and a 6-bit shift register.
REQ-014 HUNT: 00 increments idle_cnt; any other pair clears idle_cnt; on the edge sampling the IDLE_MIN-th consecutive 00, go to ARMED.
REQ-015 ARMED: 00 stays; 10 goes to DATA with slot = 0; 01 or 11 goes to HUNT with idle_cnt = 0.
REQ-016 DATA: each edge shifts rx_pair into the shift register and increments slot; data pairs are not checked.
REQ-017 DATA at slot 3: on that same edge, set data_out = {shift[5:0], rx_pair}, pulse data_valid, increment good_cnt, and go to SYNC.
REQ-018 SYNC with 10: go to DATA with slot = 0.
REQ-019 SYNC with 00: treat as orderly link stop; go to HUNT with idle_cnt = 1, good_cnt = 0, and locked = 0, with no frame_err.
REQ-020 SYNC with 01 or 11: pulse frame_err, increment err_count (saturating at 255), clear good_cnt and locked, and go to HUNT with idle_cnt = 0.
REQ-021 locked SHALL assert on the edge good_cnt reaches LOCK_FRAMES and stays high until REQ-019 or REQ-020 clears it.
REQ-022 data_valid SHALL pulse for every completed frame regardless of locked.
REQ-023 data_out SHALL hold its value between pulses.
REQ-024 Latency: data_valid and data_out SHALL update on the edge sampling the 4th data pair, i.e. 4 clocks after the sync-pair edge.
REQ-025 err_clr SHALL zero err_count on the next edge; if it coincides with a frame_err, the result SHALL be err_count = 0.
REQ-026 Loss of clk (gated transmitter clock) SHALL freeze all state; there is no timeout.

Reset
REQ-027 While reset_n is low, asynchronously: state = HUNT, idle_cnt = 0, slot = 0, good_cnt = 0, shift = 0, data_out = 8'h00, data_valid = 0, locked = 0, frame_err = 0, err_count = 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial byte with no data_valid or frame_err pulse.
REQ-029 After release, the block SHALL require a full IDLE_MIN idle run before accepting a sync.

Verification
REQ-030 Startup: 16 x 00, then 10, 11, 00, 10, 01 -> data_valid once with data_out = 8'hC9 on the 4th data edge, frame_err = 0.
REQ-031 Lock: idle run, then 3 back-to-back frames 8'hA5, 8'h3C, 8'hFF -> locked rises with the 2nd data_valid and data_out sequence is A5, 3C, FF.
REQ-032 Short idle: 15 x 00, then 10 -> stays in HUNT, no data_valid; after one more 00, then 10 -> frame accepted.
REQ-033 Bad sync: locked link, sync slot = 11 -> one frame_err pulse, err_count = 1, locked = 0, no data_valid until a new 16-idle run and a good frame.
REQ-034 Orderly stop and data mimic: locked link, sync slot = 00 -> locked = 0, frame_err = 0; separately, byte 8'h88 (pairs 10, 00, 10, 00) inside a frame does not resync and is delivered as 8'h88.
REQ-035 Reset and saturation: reset_n low during data slot 2 -> outputs zero immediately and no pulse follows; 300 bad syncs -> err_count = 255, then err_clr -> 0.
